// File: rtl/mod_cntr_ctrl_pkg.sv
// Shared types and default constants for the programmable modulo counter controller.
package mod_cntr_ctrl_pkg;

    localparam int unsigned DEF_N       = 10;
    localparam int unsigned DEF_MODULUS = 10;
    localparam int unsigned DEF_WRAP_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

endpackage

// File: rtl/mod_cntr_core.sv
// N-bit modulo counter datapath: clear has priority, inc advances and wraps at mod-1.
module mod_cntr_core #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    input  logic [N-1:0] mod,
    output logic [N-1:0] cnt,
    output logic         at_last
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] cnt_r;
    logic [N-1:0] last_s;

    assign last_s  = mod - ONE;
    assign at_last = (cnt_r == last_s);
    assign cnt     = cnt_r;

    // Count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (inc) begin
            cnt_r <= at_last ? '0 : (cnt_r + ONE);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/mod_cntr_ctrl.sv
// Run-time controller for a programmable modulo counter: config handshake, start/stop
// sequencing, terminal-count pulse, saturating period count and done status.
module mod_cntr_ctrl
    import mod_cntr_ctrl_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int DEF_MOD = DEF_MODULUS,
    parameter int WRAP_W  = DEF_WRAP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [N-1:0]      cfg_mod,
    input  logic              cfg_oneshot,
    output logic              cfg_err,
    input  logic              start,
    input  logic              stop,
    input  logic              en,
    output logic [N-1:0]      cnt,
    output logic              tc,
    output logic [WRAP_W-1:0] wraps,
    output logic              busy,
    output logic              done
);

    state_e              state_r;
    state_e              state_s;
    logic [N-1:0]        mod_r;
    mode_e               mode_r;
    // The run keeps its own copy so a handshake coinciding with start only affects the next run.
    logic [N-1:0]        run_mod_r;
    mode_e               run_mode_r;
    logic                tc_r;
    logic                cfg_err_r;
    logic                busy_r;
    logic                done_r;
    logic [WRAP_W-1:0]   wraps_r;
    logic                hs_s;
    logic                clear_s;
    logic                inc_s;
    logic                wrap_s;
    logic                launch_s;
    logic                at_last_s;

    function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
        if (v == {WRAP_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(WRAP_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign cfg_ready = (state_r != ST_RUN);
    assign hs_s      = cfg_valid & cfg_ready;
    assign cfg_err   = cfg_err_r;
    assign tc        = tc_r;
    assign wraps     = wraps_r;
    assign busy      = busy_r;
    assign done      = done_r;

    mod_cntr_core #(.N(N)) u_core (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear_s),
        .inc     (inc_s),
        .mod     (run_mod_r),
        .cnt     (cnt),
        .at_last (at_last_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and counter control; stop outranks both start and terminal count
    always_comb begin
        state_s  = state_r;
        clear_s  = 1'b0;
        inc_s    = 1'b0;
        wrap_s   = 1'b0;
        launch_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (stop) begin
                    state_s = ST_IDLE;
                    clear_s = 1'b1;
                end else if (en) begin
                    inc_s = 1'b1;
                    if (at_last_s) begin
                        wrap_s = 1'b1;
                        if (run_mode_r == MODE_ONESHOT) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_IDLE, ST_DONE: begin
                if (stop) begin
                    state_s = ST_IDLE;
                end else if (start) begin
                    state_s  = ST_RUN;
                    clear_s  = 1'b1;
                    launch_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                clear_s = 1'b1;
            end
        endcase
    end

    // Configuration registers and run snapshot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mod_r      <= N'(DEF_MOD);
            mode_r     <= MODE_PERIODIC;
            run_mod_r  <= N'(DEF_MOD);
            run_mode_r <= MODE_PERIODIC;
            cfg_err_r  <= 1'b0;
        end else begin
            if (hs_s && (cfg_mod != {N{1'b0}})) begin
                mod_r  <= cfg_mod;
                mode_r <= mode_e'(cfg_oneshot);
            end else begin
                mod_r  <= mod_r;
                mode_r <= mode_r;
            end
            if (launch_s) begin
                run_mod_r  <= mod_r;
                run_mode_r <= mode_r;
            end else begin
                run_mod_r  <= run_mod_r;
                run_mode_r <= run_mode_r;
            end
            cfg_err_r <= hs_s && (cfg_mod == {N{1'b0}});
        end
    end

    // Status outputs: tc pulse, period count, busy/done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tc_r    <= 1'b0;
            wraps_r <= {WRAP_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            tc_r <= wrap_s;
            if (launch_s) begin
                wraps_r <= {WRAP_W{1'b0}};
            end else if (wrap_s) begin
                wraps_r <= sat_inc(wraps_r);
            end else begin
                wraps_r <= wraps_r;
            end
            busy_r <= (state_s == ST_RUN);
            done_r <= (state_s == ST_DONE);
        end
    end

endmodule

// File: tb/tb_mod_cntr_ctrl.sv
// Scoreboard bench for mod_cntr_ctrl: a behavioural model predicts each cycle's outputs,
// a monitor compares them one step after every rising edge.
module tb_mod_cntr_ctrl;

    localparam int N      = 10;
    localparam int WRAP_W = 8;
    localparam int DEFMOD = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [N-1:0]      cfg_mod = '0;
    logic              cfg_oneshot = 1'b0;
    logic              cfg_err;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              en = 1'b0;
    logic [N-1:0]      cnt;
    logic              tc;
    logic [WRAP_W-1:0] wraps;
    logic              busy;
    logic              done;

    mod_cntr_ctrl #(.N(N), .DEF_MOD(DEFMOD), .WRAP_W(WRAP_W)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mod(cfg_mod), .cfg_oneshot(cfg_oneshot), .cfg_err(cfg_err),
        .start(start), .stop(stop), .en(en), .cnt(cnt), .tc(tc),
        .wraps(wraps), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int tc;
        int wraps;
        int busy;
        int done;
        int ready;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_tc   = 0;

    // Behavioural model: phase 0 idle, 1 counting, 2 finished
    int m_phase, m_cnt, m_wraps, m_mod, m_one, m_amod, m_aone;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_wraps = 0;
        m_mod = DEFMOD; m_one = 0; m_amod = DEFMOD; m_aone = 0;
    endtask

    function automatic exp_t model_step(input int cv, input int cm, input int co,
                                        input int s, input int p, input int e);
        exp_t r;
        int   accept;
        r.tc   = 0;
        accept = cv && (m_phase != 1);
        r.err  = accept && (cm == 0);
        if (m_phase == 1) begin
            if (p) begin
                m_phase = 0; m_cnt = 0;
            end else if (e) begin
                m_cnt = (m_cnt + 1) % m_amod;
                if (m_cnt == 0) begin
                    r.tc = 1;
                    m_wraps = (m_wraps + 1 > 255) ? 255 : m_wraps + 1;
                    if (m_aone) m_phase = 2;
                end
            end
        end else if (p) begin
            m_phase = 0;
        end else if (s) begin
            m_phase = 1; m_cnt = 0; m_wraps = 0; m_amod = m_mod; m_aone = m_one;
        end
        if (accept && cm != 0) begin
            m_mod = cm; m_one = co;
        end
        r.cnt = m_cnt; r.wraps = m_wraps;
        r.busy = (m_phase == 1); r.done = (m_phase == 2); r.ready = (m_phase != 1);
        return r;
    endfunction

    task automatic cyc(input int cv, input int cm, input int co, input int s, input int p, input int e);
        @(negedge clk);
        cfg_valid = cv[0]; cfg_mod = cm[N-1:0]; cfg_oneshot = co[0];
        start = s[0]; stop = p[0]; en = e[0];
        exp_q.push_back(model_step(cv, cm, co, s, p, e));
    endtask

    task automatic drain();
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_tc", int'(tc), 0);
        chk("rst_wraps", int'(wraps), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(cfg_err), 0);
        chk("rst_ready", int'(cfg_ready), 1);
    endtask

    // Monitor: compares DUT outputs against the oldest prediction after each rising edge
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cnt", int'(cnt), e.cnt);
            chk("tc", int'(tc), e.tc);
            chk("wraps", int'(wraps), e.wraps);
            chk("busy", int'(busy), e.busy);
            chk("done", int'(done), e.done);
            chk("cfg_ready", int'(cfg_ready), e.ready);
            chk("cfg_err", int'(cfg_err), e.err);
            if (e.tc != 0) n_tc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tc_before;
        model_reset();
        #12;
        chk_reset_outputs();
        @(negedge clk);
        rst = 1'b1;

        // Illegal modulus in IDLE, then periodic run at the default modulus
        cyc(1, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        tc_before = n_tc;
        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 35; i++) cyc(0, 0, 0, 0, 0, 1);
        drain();
        chk("periodic_tc_count", n_tc - tc_before, 3);
        cyc(0, 0, 0, 0, 1, 0);

        // One-shot modulus 4
        cyc(1, 4, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 0);

        // Enable gating at modulus 3, with a handshake in the start cycle
        cyc(1, 3, 0, 0, 0, 0);
        cyc(1, 7, 0, 1, 0, 0);
        for (int i = 0; i < 14; i++) cyc(0, 0, 0, 0, 0, i % 2 == 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0, 1);

        // Offer held through RUN, accepted after stop
        for (int i = 0; i < 4; i++) cyc(1, 5, 0, 0, 0, 1);
        cyc(1, 5, 0, 0, 1, 1);
        cyc(1, 5, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 0, 1);

        // Stop coinciding with the terminal count
        for (int i = 0; i < 10 && !(m_phase == 1 && m_cnt == m_amod - 1); i++) cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1, 1);
        cyc(0, 0, 0, 0, 0, 1);

        // Modulus 1 saturates the period count
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 300; i++) cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 0);

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 6), $urandom_range(0, 1),
                $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
        end

        // Asynchronous reset in the middle of a run with a non-default modulus
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 6, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        drain();
        chk("pre_reset_busy", int'(busy), 1);
        rst = 1'b0;
        #1;
        chk_reset_outputs();
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mod_cntr_ctrl.md
Name: mod_cntr_ctrl

Overview:
- Run-time controller for a programmable modulo counter.
- Accepts a modulus and mode through a valid/ready configuration handshake.
- Sequences start, stop and count-enable, and reports a terminal-count pulse, a completed-period count and a done status.
- Sits between a register/host interface and any logic that needs periodic or one-shot ticks of programmable length.

Parameters:
- N, 10, counter and modulus width in bits.
- DEF_MOD, 10, modulus loaded at reset; must satisfy 1 <= DEF_MOD <= 2^N-1.
- WRAP_W, 8, width of the completed-period counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset; 0 = reset.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  configuration may be accepted this cycle.
- cfg_mod  in  N  requested modulus.
- cfg_oneshot  in  1  0 = periodic, 1 = one-shot.
- cfg_err  out  1  one-cycle pulse: the offered modulus was rejected.
- start  in  1  begin counting.
- stop  in  1  abort counting.
- en  in  1  count enable; qualifies each increment.
- cnt  out  N  current count value.
- tc  out  1  one-cycle terminal-count pulse.
- wraps  out  WRAP_W  number of completed periods since the last start; saturates.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, mod_q=DEF_MOD, oneshot_q=0.
  - cnt=0, tc=0, wraps=0, busy=0, done=0, cfg_err=0.
  - cfg_ready is combinational and equals 1 in IDLE.
- States: IDLE, RUN, DONE. Encoding is defined in the package.
- cfg_ready is 1 in IDLE and DONE, 0 in RUN.
- Configuration handshake (cfg_valid & cfg_ready):
  - cfg_mod != 0: mod_q<=cfg_mod and oneshot_q<=cfg_oneshot on that edge.
  - cfg_mod == 0: configuration unchanged; cfg_err=1 for the next cycle only.
  - cfg_valid in RUN is ignored; the host must hold it until cfg_ready.
- Handshake and start in the same cycle: start uses the old configuration; the new configuration applies from the next start.
- IDLE/DONE + start (stop=0):
  - Next cycle: state=RUN, cnt=0, wraps=0, done=0.
  - Counting begins the cycle after entry.
- RUN, en=1, cnt != mod_q-1: cnt<=cnt+1.
- RUN, en=1, cnt == mod_q-1:
  - cnt<=0 and tc=1 in the following cycle (registered pulse, coincident with cnt=0).
  - wraps<=wraps+1, saturating at 2^WRAP_W-1.
  - Periodic: remain in RUN.
  - One-shot: state<=DONE, busy=0, done=1.
- RUN, en=0: all state holds; no tc.
- mod_q=1: cnt stays 0; tc asserts in each cycle following a cycle with en=1.
- RUN + stop:
  - Next cycle: state=IDLE, cnt=0, no tc, and wraps holds its value.
  - Stop has priority over a simultaneous terminal count (no tc, no wraps increment).
  - Stop has priority over a simultaneous start.
- DONE: cnt=0, done=1 until the next start. stop in DONE returns to IDLE and clears done.
- start while in RUN is ignored.
- Arithmetic: cnt compared with mod_q-1 at N-bit width. mod_q=0 cannot occur.
- Asynchronous reset mid-run: immediate return to the reset values and to DEF_MOD.

Decomposition:
- Package mod_cntr_ctrl_pkg:
  - state enum (ST_IDLE, ST_RUN, ST_DONE).
  - mode enum (MODE_PERIODIC, MODE_ONESHOT).
  - Default-parameter constants.
- Sub-module mod_cntr_core: N-bit counter with inputs clear, inc, mod and output at_last (cnt == mod-1). The FSM, configuration registers, tc and wraps stay in mod_cntr_ctrl.

Test Plan:
- Periodic, default configuration:
  - Stimulus: reset; start; en=1 for 35 cycles.
  - Expected: cnt 0..9 repeating; tc high 3 times, each coincident with cnt=0 after 9; wraps=3; busy=1 throughout.
- One-shot:
  - Stimulus: configure cfg_mod=4, cfg_oneshot=1; start; en=1.
  - Expected: cnt 0,1,2,3,0; tc once; then done=1, busy=0, cnt held at 0, cfg_ready=1.
- Enable gating:
  - Stimulus: cfg_mod=3 periodic; en toggles 1,0,1,0,...
  - Expected: cnt advances only on en=1 cycles; tc after 3 enabled cycles; wraps increments once per 3 enables.
- Illegal and mid-run configuration:
  - Stimulus: cfg_mod=0 in IDLE.
  - Expected: cfg_err pulse of 1 cycle; mod_q stays 10.
  - Stimulus: cfg_valid with cfg_mod=5 during RUN.
  - Expected: cfg_ready=0 and no change; the offer is accepted after stop, and the next run wraps at 5.
- Stop priority:
  - Stimulus: stop asserted in the same cycle as cnt=mod_q-1 with en=1.
  - Expected: IDLE next cycle, cnt=0, no tc, wraps unchanged.
  - Stimulus: start and stop together in IDLE.
  - Expected: remains IDLE.
- Edge cases:
  - Stimulus: cfg_mod=1 with en=1 for 300 cycles.
  - Expected: tc every cycle; wraps saturates at 255.
  - Stimulus: async rst=0 mid-run.
  - Expected: all outputs at reset values immediately; the modulus returns to 10.
